// File: rtl/alu16b.sv
// 16-bit registered ALU: add/sub/shift/logic/not/neg with zero and signed-overflow flags.
// One clock latency; define ALU_SLT_EN to turn opcode 8 into a signed set-less-than.
module alu16b #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUop,
  output logic [WIDTH-1:0] S,
  output logic             IsZero,
  output logic             OFL
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_SLL = 4'd2;
  localparam logic [3:0] OP_SRL = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_NOT = 4'd7;
`ifdef ALU_SLT_EN
  localparam logic [3:0] OP_SLT = 4'd8;
`endif
  localparam logic [3:0] OP_NEG = 4'd9;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] neg;
  logic [SHW-1:0]   shamt;
  logic             shift_big;
  logic [WIDTH-1:0] res;
  logic             ofl;
`ifdef ALU_SLT_EN
  logic             slt;
`endif

  assign sum       = A + B;
  assign diff      = A - B;
  assign neg       = '0 - A;
  assign shamt     = B[SHW-1:0];
  // Any set bit above the low shift-amount field means the shift clears everything.
  assign shift_big = |B[WIDTH-1:SHW];
`ifdef ALU_SLT_EN
  assign slt       = $signed(A) < $signed(B);
`endif

  always_comb begin
    res = '0;
    ofl = 1'b0;
    case (ALUop)
      OP_ADD: begin
        res = sum;
        ofl = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        res = diff;
        ofl = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLL: res = shift_big ? '0 : (A << shamt);
      OP_SRL: res = shift_big ? '0 : (A >> shamt);
      OP_AND: res = A & B;
      OP_OR:  res = A | B;
      OP_XOR: res = A ^ B;
      OP_NOT: res = ~A;
`ifdef ALU_SLT_EN
      OP_SLT: res = {{(WIDTH-1){1'b0}}, slt};
`endif
      OP_NEG: begin
        res = neg;
        // Only the most negative value has no positive counterpart.
        ofl = A[WIDTH-1] && neg[WIDTH-1];
      end
      default: begin
        res = '0;
        ofl = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      S      <= '0;
      IsZero <= 1'b1;
      OFL    <= 1'b0;
    end else begin
      S      <= res;
      IsZero <= (res == '0);
      OFL    <= ofl;
    end
  end

endmodule

// File: tb/tb_alu16b.sv
// Bench for alu16b: integer-arithmetic reference model checked every cycle plus directed vectors
// with hand-computed expectations.
module tb_alu16b;

  logic        clk;
  logic        rst_n;
  logic [15:0] A;
  logic [15:0] B;
  logic [3:0]  ALUop;
  logic [15:0] S;
  logic        IsZero;
  logic        OFL;

  int n_vec = 0;
  int n_err = 0;

  alu16b #(.WIDTH(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .A      (A),
    .B      (B),
    .ALUop  (ALUop),
    .S      (S),
    .IsZero (IsZero),
    .OFL    (OFL)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  // Reference: compute with wide signed integers and range-check, rather than sign-bit tricks.
  function automatic void model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] s, output logic o);
    int sa, sb, ua, r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    ua = int'(a);
    r  = 0;
    s  = 16'h0000;
    o  = 1'b0;
    case (op)
      4'd0: begin r = sa + sb; s = r[15:0]; o = (r > 32767) || (r < -32768); end
      4'd1: begin r = sa - sb; s = r[15:0]; o = (r > 32767) || (r < -32768); end
      4'd2: begin r = (b >= 16'd16) ? 0 : (ua << b); s = r[15:0]; end
      4'd3: begin r = (b >= 16'd16) ? 0 : (ua >> b); s = r[15:0]; end
      4'd4: s = a & b;
      4'd5: s = a | b;
      4'd6: s = a ^ b;
      4'd7: s = ~a;
`ifdef ALU_SLT_EN
      4'd8: s = (sa < sb) ? 16'h0001 : 16'h0000;
`endif
      4'd9: begin r = -sa; s = r[15:0]; o = (r > 32767); end
      default: s = 16'h0000;
    endcase
  endfunction

  logic        m_valid = 1'b0;
  logic [15:0] exp_s;
  logic        exp_z;
  logic        exp_o;

  always @(posedge clk) begin
    logic [15:0] ms;
    logic        mo;
    model(ALUop, A, B, ms, mo);
    if (!rst_n) begin
      ms = 16'h0000;
      mo = 1'b0;
    end
    exp_s   = ms;
    exp_z   = (ms == 16'h0000);
    exp_o   = mo;
    m_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model.S", S, exp_s);
      chk("model.IsZero", {15'd0, IsZero}, {15'd0, exp_z});
      chk("model.OFL", {15'd0, OFL}, {15'd0, exp_o});
    end
  end

  // Drive at a negedge, result is registered at the next posedge and checked at the following negedge.
  task automatic vec(input string nm, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] es, input logic ez, input logic eo);
    ALUop = op;
    A     = a;
    B     = b;
    @(negedge clk);
    chk({nm, ".S"}, S, es);
    chk({nm, ".IsZero"}, {15'd0, IsZero}, {15'd0, ez});
    chk({nm, ".OFL"}, {15'd0, OFL}, {15'd0, eo});
  endtask

  initial begin
    rst_n = 1'b0;
    ALUop = 4'd0;
    A     = 16'd5;
    B     = 16'd6;
    @(negedge clk);
    @(negedge clk);
    chk("reset.S", S, 16'h0000);
    chk("reset.IsZero", {15'd0, IsZero}, 16'h0001);
    chk("reset.OFL", {15'd0, OFL}, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset.S", S, 16'd11);

    vec("add_small",   4'd0, 16'd500,  16'd600,  16'd1100, 1'b0, 1'b0);
    vec("add_ovf_pos", 4'd0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);
    vec("add_ovf_neg", 4'd0, 16'h8AD0, 16'hF52F, 16'h7FFF, 1'b0, 1'b1);
    vec("add_zero",    4'd0, 16'h1B58, 16'hE4A8, 16'h0000, 1'b1, 1'b0);
    vec("add_carry",   4'd0, 16'h7FFF, 16'h8001, 16'h0000, 1'b1, 1'b0);

    vec("sub_0m1",     4'd1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0);
    vec("sub_ovf_pos", 4'd1, 16'h7FFF, 16'hFFFF, 16'h8000, 1'b0, 1'b1);
    vec("sub_noovf",   4'd1, 16'h0003, 16'h7FFF, 16'h8004, 1'b0, 1'b0);
    vec("sub_ovf_neg", 4'd1, 16'h8001, 16'h0003, 16'h7FFE, 1'b0, 1'b1);

    vec("sll_6_1",     4'd2, 16'h0006, 16'd1,    16'h000C, 1'b0, 1'b0);
    vec("sll_ffff_1",  4'd2, 16'hFFFF, 16'd1,    16'hFFFE, 1'b0, 1'b0);
    vec("sll_out",     4'd2, 16'h4000, 16'd2,    16'h0000, 1'b1, 1'b0);
    vec("sll_bighi",   4'd2, 16'h0001, 16'h0100, 16'h0000, 1'b1, 1'b0);
    vec("srl_ffff_1",  4'd3, 16'hFFFF, 16'd1,    16'h7FFF, 1'b0, 1'b0);
    vec("srl_78_7",    4'd3, 16'h0078, 16'd7,    16'h0000, 1'b1, 1'b0);
    vec("srl_16",      4'd3, 16'h1234, 16'd16,   16'h0000, 1'b1, 1'b0);
    vec("srl_15",      4'd3, 16'h8000, 16'd15,   16'h0001, 1'b0, 1'b0);

    vec("and",         4'd4, 16'h30F0, 16'hF81C, 16'h3010, 1'b0, 1'b0);
    vec("or",          4'd5, 16'h30F0, 16'hF81C, 16'hF8FC, 1'b0, 1'b0);
    vec("xor",         4'd6, 16'h30F0, 16'hF81C, 16'hC8EC, 1'b0, 1'b0);
    vec("not",         4'd7, 16'h30F0, 16'hF81C, 16'hCF0F, 1'b0, 1'b0);
    vec("not_ffff",    4'd7, 16'hFFFF, 16'h1234, 16'h0000, 1'b1, 1'b0);
    vec("and_noofl",   4'd4, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0);

    vec("neg_500",     4'd9, 16'd500,  16'hFFFF, 16'hFE0C, 1'b0, 1'b0);
    vec("neg_m7000",   4'd9, 16'hE4A8, 16'h0000, 16'h1B58, 1'b0, 1'b0);
    vec("neg_min",     4'd9, 16'h8000, 16'h0000, 16'h8000, 1'b0, 1'b1);
    vec("neg_zero",    4'd9, 16'h0000, 16'h7777, 16'h0000, 1'b1, 1'b0);

    vec("rsv_10",      4'd10, 16'h7FFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
    vec("rsv_15",      4'd15, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 1'b0);
`ifdef ALU_SLT_EN
    vec("slt_m1_1",    4'd8, 16'hFFFF, 16'h0001, 16'h0001, 1'b0, 1'b0);
    vec("slt_1_m1",    4'd8, 16'h0001, 16'hFFFF, 16'h0000, 1'b1, 1'b0);
    vec("slt_span",    4'd8, 16'h8000, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
`else
    vec("rsv_8",       4'd8, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
`endif

    // Back-to-back different ops: one result per edge, no bubbles.
    vec("pipe0",       4'd0, 16'd1,    16'd2,    16'd3,    1'b0, 1'b0);
    vec("pipe1",       4'd6, 16'h00FF, 16'h0F0F, 16'h0FF0, 1'b0, 1'b0);
    vec("pipe2",       4'd3, 16'h8000, 16'd4,    16'h0800, 1'b0, 1'b0);
    vec("pipe3",       4'd1, 16'd10,   16'd10,   16'h0000, 1'b1, 1'b0);

    // Reset in mid-stream overrides the pending operation.
    ALUop = 4'd0;
    A     = 16'h7FFF;
    B     = 16'h0001;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_reset.S", S, 16'h0000);
    chk("mid_reset.OFL", {15'd0, OFL}, 16'h0000);
    rst_n = 1'b1;
    vec("after_mid",   4'd0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);

    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      ALUop = 4'($urandom_range(0, 15));
      A     = 16'($urandom);
      B     = (i % 3 == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
    end
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
